// File: rtl/instruction_loader_pkg.sv
// Shared constants and types for the instruction loader and the fetch/ID stages
// that recognise the HALT word as a pipeline stop.
package instruction_loader_pkg;

    localparam int WORD_WIDTH             = 32;
    localparam int BYTE_WIDTH             = 8;
    localparam int DEFAULT_MEM_ADDR_WIDTH = 10;

    localparam logic [WORD_WIDTH-1:0] CODE_INSTR_HALT = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        CODE_LOADER_ST_IDLE    = 3'd0,
        CODE_LOADER_ST_RECEIVE = 3'd1,
        CODE_LOADER_ST_WRITE   = 3'd2,
        CODE_LOADER_ST_DONE    = 3'd3,
        CODE_LOADER_ST_ERROR   = 3'd4
    } loader_state_t;

endpackage

// File: rtl/instruction_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface instruction_loader_if
    import instruction_loader_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = DEFAULT_MEM_ADDR_WIDTH
);
    logic                      i_start;
    logic                      i_rx_valid;
    logic [BYTE_WIDTH-1:0]     i_rx_byte;
    logic                      o_mem_write;
    logic [MEM_ADDR_WIDTH-1:0] o_mem_addr;
    logic [WORD_WIDTH-1:0]     o_mem_data;
    logic                      o_busy;
    logic                      o_done;
    logic                      o_error;
    logic [MEM_ADDR_WIDTH:0]   o_word_count;

    modport master (
        output i_start, i_rx_valid, i_rx_byte,
        input  o_mem_write, o_mem_addr, o_mem_data, o_busy, o_done, o_error, o_word_count
    );

    modport slave (
        input  i_start, i_rx_valid, i_rx_byte,
        output o_mem_write, o_mem_addr, o_mem_data, o_busy, o_done, o_error, o_word_count
    );
endinterface

// File: rtl/instruction_loader_word_assembler.sv
// Packs four bytes MSB-first into a word; o_word/o_word_ready show the word
// completed by the byte presented this cycle.
module word_assembler
    import instruction_loader_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_clear,
    input  logic                  i_valid,
    input  logic [BYTE_WIDTH-1:0] i_byte,
    output logic [WORD_WIDTH-1:0] o_word,
    output logic                  o_word_ready
);
    logic [WORD_WIDTH-1:0] shift_q;
    logic [1:0]            count_q;

    assign o_word       = {shift_q[WORD_WIDTH-BYTE_WIDTH-1:0], i_byte};
    assign o_word_ready = i_valid && (count_q == 2'd3);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            shift_q <= '0;
            count_q <= '0;
        end else if (i_clear) begin
            shift_q <= '0;
            count_q <= '0;
        end else if (i_valid) begin
            shift_q <= o_word;
            count_q <= count_q + 2'd1;
        end
    end
endmodule

// File: rtl/instruction_loader.sv
// Loads instruction memory from a UART byte stream until the HALT word is written.
module instruction_loader
    import instruction_loader_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = DEFAULT_MEM_ADDR_WIDTH
)(
    input  logic              i_clk,
    input  logic              i_reset,
    instruction_loader_if.slave bus
);
    loader_state_t             state_q, state_d;
    logic                      in_session;
    logic                      start_accept;
    logic                      byte_accept;
    logic [WORD_WIDTH-1:0]     word;
    logic                      word_ready;

    logic                      mem_write_q;
    logic [MEM_ADDR_WIDTH-1:0] addr_q;
    logic [WORD_WIDTH-1:0]     data_q;
    logic                      busy_q;
    logic                      done_q;
    logic                      error_q;
    logic [MEM_ADDR_WIDTH:0]   count_q;

    assign in_session   = (state_q == CODE_LOADER_ST_RECEIVE) || (state_q == CODE_LOADER_ST_WRITE);
    assign start_accept = bus.i_start && !in_session;
    assign byte_accept  = bus.i_rx_valid && in_session;

    word_assembler u_word_assembler (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_clear      (start_accept),
        .i_valid      (byte_accept),
        .i_byte       (bus.i_rx_byte),
        .o_word       (word),
        .o_word_ready (word_ready)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) state_q <= CODE_LOADER_ST_IDLE;
        else         state_q <= state_d;
    end

    // NOTE: state_d gets its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            CODE_LOADER_ST_IDLE,
            CODE_LOADER_ST_DONE,
            CODE_LOADER_ST_ERROR: begin
                if (start_accept) state_d = CODE_LOADER_ST_RECEIVE;
            end
            CODE_LOADER_ST_RECEIVE: begin
                if (word_ready) state_d = CODE_LOADER_ST_WRITE;
            end
            CODE_LOADER_ST_WRITE: begin
                if (data_q == CODE_INSTR_HALT)  state_d = CODE_LOADER_ST_DONE;
                else if (addr_q == '1)          state_d = CODE_LOADER_ST_ERROR;
                else                            state_d = CODE_LOADER_ST_RECEIVE;
            end
            default: state_d = CODE_LOADER_ST_IDLE;
        endcase
    end

    // Outputs are registered from state_d so the write pulse lines up with the WRITE state.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            mem_write_q <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            count_q     <= '0;
        end else begin
            mem_write_q <= (state_d == CODE_LOADER_ST_WRITE);
            busy_q      <= (state_d == CODE_LOADER_ST_RECEIVE) || (state_d == CODE_LOADER_ST_WRITE);
            done_q      <= (state_d == CODE_LOADER_ST_DONE);
            error_q     <= (state_d == CODE_LOADER_ST_ERROR);
            if (start_accept) begin
                addr_q  <= '0;
                count_q <= '0;
            end
            if (word_ready) data_q <= word;
            if (state_q == CODE_LOADER_ST_WRITE) begin
                count_q <= count_q + 1'b1;
                if (state_d == CODE_LOADER_ST_RECEIVE) addr_q <= addr_q + 1'b1;
            end
        end
    end

    assign bus.o_mem_write  = mem_write_q;
    assign bus.o_mem_addr   = addr_q;
    assign bus.o_mem_data   = data_q;
    assign bus.o_busy       = busy_q;
    assign bus.o_done       = done_q;
    assign bus.o_error      = error_q;
    assign bus.o_word_count = count_q;
endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench: a 1024-word loader and a 4-word loader share clock and reset.
module tb_instruction_loader;
    import instruction_loader_pkg::*;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    logic [31:0] q_addr[$];
    logic [31:0] q_data[$];
    logic [31:0] q2_addr[$];
    logic [31:0] q2_data[$];

    instruction_loader_if #(.MEM_ADDR_WIDTH(10)) bus ();
    instruction_loader_if #(.MEM_ADDR_WIDTH(2))  bus2 ();

    instruction_loader #(.MEM_ADDR_WIDTH(10)) dut  (.i_clk(clk), .i_reset(rst), .bus(bus));
    instruction_loader #(.MEM_ADDR_WIDTH(2))  dut2 (.i_clk(clk), .i_reset(rst), .bus(bus2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.o_mem_write) begin
            q_addr.push_back(32'(bus.o_mem_addr));
            q_data.push_back(bus.o_mem_data);
        end
        if (bus2.o_mem_write) begin
            q2_addr.push_back(32'(bus2.o_mem_addr));
            q2_data.push_back(bus2.o_mem_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Every helper starts and ends on a falling edge.
    task automatic pulse_start(input bit sel);
        if (sel) bus2.i_start = 1'b1; else bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start  = 1'b0;
        bus2.i_start = 1'b0;
    endtask

    task automatic put_byte(input bit sel, input logic [7:0] b);
        if (sel) begin bus2.i_rx_valid = 1'b1; bus2.i_rx_byte = b; end
        else     begin bus.i_rx_valid  = 1'b1; bus.i_rx_byte  = b; end
        @(negedge clk);
    endtask

    task automatic stop_bytes();
        bus.i_rx_valid  = 1'b0;
        bus2.i_rx_valid = 1'b0;
    endtask

    task automatic put_word(input bit sel, input logic [31:0] w);
        put_byte(sel, w[31:24]);
        put_byte(sel, w[23:16]);
        put_byte(sel, w[15:8]);
        put_byte(sel, w[7:0]);
    endtask

    task automatic clear_logs();
        q_addr.delete();  q_data.delete();
        q2_addr.delete(); q2_data.delete();
    endtask

    initial begin
        rst = 1'b1;
        bus.i_start  = 1'b0; bus.i_rx_valid  = 1'b0; bus.i_rx_byte  = '0;
        bus2.i_start = 1'b0; bus2.i_rx_valid = 1'b0; bus2.i_rx_byte = '0;
        idle(2);
        check("rst_write", 32'(bus.o_mem_write), 32'd0);
        check("rst_addr",  32'(bus.o_mem_addr),  32'd0);
        check("rst_data",  bus.o_mem_data,       32'd0);
        check("rst_busy",  32'(bus.o_busy),      32'd0);
        check("rst_done",  32'(bus.o_done),      32'd0);
        check("rst_error", 32'(bus.o_error),     32'd0);
        check("rst_count", 32'(bus.o_word_count), 32'd0);
        rst = 1'b0;
        idle(1);

        // Bytes in IDLE are ignored.
        put_byte(0, 8'h12); put_byte(0, 8'h34); stop_bytes(); idle(3);
        check("idle_nowrite", 32'(q_addr.size()), 32'd0);
        check("idle_busy",    32'(bus.o_busy),    32'd0);

        // Gapped stream: 20 08 00 05 then HALT.
        pulse_start(0);
        check("s1_busy", 32'(bus.o_busy), 32'd1);
        put_byte(0, 8'h20); stop_bytes(); idle(1);
        put_byte(0, 8'h08); stop_bytes(); idle(1);
        put_byte(0, 8'h00); stop_bytes(); idle(1);
        put_byte(0, 8'h05);
        check("s1_w0_write", 32'(bus.o_mem_write), 32'd1);
        check("s1_w0_addr",  32'(bus.o_mem_addr),  32'd0);
        check("s1_w0_data",  bus.o_mem_data,       32'h2008_0005);
        stop_bytes(); idle(1);
        check("s1_mid_write", 32'(bus.o_mem_write), 32'd0);
        check("s1_mid_busy",  32'(bus.o_busy),      32'd1);
        put_byte(0, 8'hFF); stop_bytes(); idle(1);
        put_byte(0, 8'hFF); stop_bytes(); idle(1);
        put_byte(0, 8'hFF); stop_bytes(); idle(1);
        put_byte(0, 8'hFF);
        check("s1_w1_write", 32'(bus.o_mem_write), 32'd1);
        check("s1_w1_addr",  32'(bus.o_mem_addr),  32'd1);
        check("s1_w1_data",  bus.o_mem_data,       32'hFFFF_FFFF);
        check("s1_done_n1",  32'(bus.o_done),      32'd0);
        stop_bytes(); idle(1);
        check("s1_done",  32'(bus.o_done),        32'd1);
        check("s1_busy0", 32'(bus.o_busy),        32'd0);
        check("s1_count", 32'(bus.o_word_count),  32'd2);
        check("s1_error", 32'(bus.o_error),       32'd0);
        idle(2);
        check("s1_nwrites", 32'(q_addr.size()), 32'd2);
        clear_logs();

        // Back-to-back stream: the first HALT byte lands in the WRITE cycle.
        pulse_start(0);
        check("s2_done_cleared", 32'(bus.o_done), 32'd0);
        put_word(0, 32'h1122_3344);
        put_word(0, 32'hFFFF_FFFF);
        stop_bytes(); idle(3);
        check("s2_nwrites", 32'(q_addr.size()), 32'd2);
        if (q_addr.size() == 2) begin
            check("s2_a0", q_addr[0], 32'd0); check("s2_d0", q_data[0], 32'h1122_3344);
            check("s2_a1", q_addr[1], 32'd1); check("s2_d1", q_data[1], 32'hFFFF_FFFF);
        end
        check("s2_done",  32'(bus.o_done),       32'd1);
        check("s2_count", 32'(bus.o_word_count), 32'd2);
        clear_logs();

        // i_start mid-word is ignored.
        pulse_start(0);
        put_byte(0, 8'hA1); put_byte(0, 8'hB2); stop_bytes();
        pulse_start(0);
        check("s3_busy_after_start", 32'(bus.o_busy), 32'd1);
        put_byte(0, 8'hC3); put_byte(0, 8'hD4);
        put_word(0, 32'hFFFF_FFFF);
        stop_bytes(); idle(3);
        check("s3_nwrites", 32'(q_addr.size()), 32'd2);
        if (q_addr.size() == 2) begin
            check("s3_d0", q_data[0], 32'hA1B2_C3D4);
            check("s3_a1", q_addr[1], 32'd1);
        end
        check("s3_count", 32'(bus.o_word_count), 32'd2);
        clear_logs();

        // Reset mid-word discards the partial word.
        pulse_start(0);
        put_byte(0, 8'h20); put_byte(0, 8'h08); stop_bytes();
        rst = 1'b1;
        idle(1);
        check("s4_rst_busy",  32'(bus.o_busy),       32'd0);
        check("s4_rst_done",  32'(bus.o_done),       32'd0);
        check("s4_rst_count", 32'(bus.o_word_count), 32'd0);
        check("s4_rst_data",  bus.o_mem_data,        32'd0);
        check("s4_rst_write", 32'(bus.o_mem_write),  32'd0);
        rst = 1'b0;
        idle(1);
        pulse_start(0);
        put_word(0, 32'hFFFF_FFFF);
        stop_bytes(); idle(3);
        check("s4_nwrites", 32'(q_addr.size()), 32'd1);
        if (q_addr.size() == 1) begin
            check("s4_a0", q_addr[0], 32'd0); check("s4_d0", q_data[0], 32'hFFFF_FFFF);
        end
        check("s4_done",  32'(bus.o_done),       32'd1);
        check("s4_count", 32'(bus.o_word_count), 32'd1);
        clear_logs();

        // 4-word memory filled without HALT.
        pulse_start(1);
        put_word(1, 32'h0102_0304);
        put_word(1, 32'h0506_0708);
        put_word(1, 32'h090A_0B0C);
        put_word(1, 32'h0D0E_0F10);
        stop_bytes(); idle(3);
        check("s5_nwrites", 32'(q2_addr.size()), 32'd4);
        if (q2_addr.size() == 4) begin
            check("s5_a0", q2_addr[0], 32'd0); check("s5_d0", q2_data[0], 32'h0102_0304);
            check("s5_a3", q2_addr[3], 32'd3); check("s5_d3", q2_data[3], 32'h0D0E_0F10);
        end
        check("s5_error", 32'(bus2.o_error),       32'd1);
        check("s5_done",  32'(bus2.o_done),        32'd0);
        check("s5_count", 32'(bus2.o_word_count),  32'd4);
        check("s5_busy",  32'(bus2.o_busy),        32'd0);
        put_word(1, 32'h5566_7788);
        stop_bytes(); idle(3);
        check("s5_no_fifth", 32'(q2_addr.size()), 32'd4);
        check("s5_error_held", 32'(bus2.o_error), 32'd1);
        clear_logs();

        // 4-word memory: HALT lands in the last location.
        pulse_start(1);
        check("s6_error_cleared", 32'(bus2.o_error), 32'd0);
        put_word(1, 32'hAAAA_0001);
        put_word(1, 32'hAAAA_0002);
        put_word(1, 32'hAAAA_0003);
        put_word(1, 32'hFFFF_FFFF);
        stop_bytes(); idle(3);
        check("s6_nwrites", 32'(q2_addr.size()), 32'd4);
        if (q2_addr.size() == 4) begin
            check("s6_a3", q2_addr[3], 32'd3); check("s6_d3", q2_data[3], 32'hFFFF_FFFF);
        end
        check("s6_done",  32'(bus2.o_done),       32'd1);
        check("s6_error", 32'(bus2.o_error),      32'd0);
        check("s6_count", 32'(bus2.o_word_count), 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
